// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: core priority with host aging and host burst lock.
// Read data returns one cycle after issue and is steered back to its requester.
module ram_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_rden,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q,
    output logic          host_locked
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wait_cnt;
    logic          age_hit;

    assign age_hit = (wait_cnt == WMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (host_gnt && host_lock) state_nxt = LOCK;
            LOCK: if (!host_lock || !host_req) state_nxt = IDLE;
        endcase
    end

    // Grants are purely combinational so the RAM sees the access in the request cycle.
    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    host_gnt = host_req && (!core_req || age_hit);
                    core_gnt = core_req && !host_gnt;
                end
                LOCK: host_gnt = host_req;
            endcase
        end
    end

    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_rden = 1'b0;
        ram_wren = 1'b0;
        if (core_gnt) begin
            ram_addr = core_addr;
            ram_data = core_wdata;
            ram_rden = !core_we;
            ram_wren = core_we;
        end else if (host_gnt) begin
            ram_addr = host_addr;
            ram_data = host_wdata;
            ram_rden = !host_we;
            ram_wren = host_we;
        end
    end

    // Host aging counter: counts denied host cycles, saturating at the threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (host_req && !host_gnt) begin
            wait_cnt <= age_hit ? wait_cnt : wait_cnt + WW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            core_rvalid <= core_gnt && !core_we;
            host_rvalid <= host_gnt && !host_we;
        end
    end

    assign core_rdata  = core_rvalid ? ram_q : '0;
    assign host_rdata  = host_rvalid ? ram_q : '0;
    assign host_locked = (state == LOCK);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed scenarios, then random traffic
// against a rule-level arbitration model and a shadow memory.
module tb_ram_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       core_req = 1'b0, core_we = 1'b0;
    logic [7:0] core_addr = '0, core_wdata = '0;
    logic       core_gnt, core_rvalid;
    logic [7:0] core_rdata;
    logic       host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [7:0] host_addr = '0, host_wdata = '0;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic [7:0] ram_addr, ram_data, ram_q;
    logic       ram_rden, ram_wren, host_locked;

    ram_port_arbiter #(.AW(8), .DW(8), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_rden(ram_rden), .ram_wren(ram_wren),
        .ram_q(ram_q), .host_locked(host_locked)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural RAM seen by the DUT, plus the shadow copy used by the model.
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= ram_rden ? mem[ram_addr] : 8'($urandom);
    end

    typedef struct {
        bit         host;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: host ownership flag and count of denied host cycles.
    bit         m_lock = 1'b0;
    int         m_denied = 0;
    bit         e_cg, e_hg;
    logic [7:0] e_addr, e_data;
    bit         e_rd, e_wr;

    always @(negedge clk) begin
        if (rst) begin
            m_lock = 1'b0;
            m_denied = 0;
            exp_q.delete();
            chk("outputs_rst",
                {11'd0, core_gnt, host_gnt, ram_rden, ram_wren,
                 ram_addr, ram_data, host_locked}, 32'd0);
        end else begin
            e_cg = 1'b0;
            e_hg = 1'b0;
            if (m_lock) e_hg = host_req;
            else if (core_req && host_req) begin
                if (m_denied >= MAX_WAIT) e_hg = 1'b1;
                else e_cg = 1'b1;
            end else begin
                e_cg = core_req;
                e_hg = host_req;
            end
            e_addr = e_cg ? core_addr : e_hg ? host_addr : 8'd0;
            e_data = e_cg ? core_wdata : e_hg ? host_wdata : 8'd0;
            e_rd = (e_cg && !core_we) || (e_hg && !host_we);
            e_wr = (e_cg && core_we) || (e_hg && host_we);
            chk("outputs",
                {11'd0, core_gnt, host_gnt, ram_rden, ram_wren,
                 ram_addr, ram_data, host_locked},
                {11'd0, e_cg, e_hg, e_rd, e_wr, e_addr, e_data, m_lock});
            if (e_wr) ref_mem[e_addr] = e_data;
            if (e_rd) exp_q.push_back('{e_hg, ref_mem[e_addr], cycle});
            m_denied = (host_req && !e_hg) ?
                       ((m_denied < MAX_WAIT) ? m_denied + 1 : m_denied) : 0;
            m_lock = m_lock ? (host_req && host_lock) : (e_hg && host_lock);
        end
    end

    // Response monitor: every read issued last cycle must come back now.
    logic [17:0] r_exp;

    always @(negedge clk) begin
        r_exp = '0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cycle - 1) begin
            if (!rst) begin
                r_exp = exp_q[0].host ? {2'b01, 8'd0, exp_q[0].data}
                                      : {2'b10, exp_q[0].data, 8'd0};
            end
            void'(exp_q.pop_front());
        end
        chk("response", {14'd0, core_rvalid, host_rvalid, core_rdata, host_rdata},
            {14'd0, r_exp});
    end

    task automatic cyc(input bit cr, input bit cw, input logic [7:0] ca,
                       input logic [7:0] cd, input bit hr, input bit hw,
                       input logic [7:0] ha, input logic [7:0] hd,
                       input bit hl);
        @(posedge clk);
        #1;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        host_lock = hl;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    endtask

    bit cg_seen, hg_seen;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[5] = 8'hA3;
        ref_mem[5] = 8'hA3;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // core-only read
        cyc(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        chk("t2_gnt", {31'd0, core_gnt}, 32'd1);
        idle();
        chk("t2_rvalid", {31'd0, core_rvalid}, 32'd1);
        chk("t2_rdata", {24'd0, core_rdata}, 32'hA3);

        // contention and host aging
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 8'(i), 8'h00, 1, 0, 8'h20, 8'h00, 0);
            chk("t3_core_gnt", {31'd0, core_gnt}, {31'd0, i != 4});
            chk("t3_host_gnt", {31'd0, host_gnt}, {31'd0, i == 4});
        end
        idle();

        // locked host burst write with core stalled
        cyc(0, 0, 8'h10, 8'h00, 1, 1, 8'h10, 8'h01, 1);
        chk("t4_first", {31'd0, host_gnt}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            cyc(1, 0, 8'h10, 8'h00, 1, 1, 8'(8'h10 + i), 8'(1 + i), 1);
            chk("t4_core_stall", {31'd0, core_gnt}, 32'd0);
            chk("t4_locked", {31'd0, host_locked}, 32'd1);
        end
        cyc(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        chk("t4_drop_cycle", {30'd0, core_gnt, host_locked}, 32'd1);
        cyc(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        chk("t4_core_back", {30'd0, core_gnt, host_locked}, 32'd2);
        for (int i = 1; i < 5; i++) begin
            cyc(i < 4, 0, 8'(8'h10 + i), 8'h00, 0, 0, 8'h00, 8'h00, 0);
            chk("t4_readback", {23'd0, core_rvalid, core_rdata}, {23'd1, 8'(i)});
        end

        // alternating back-to-back reads
        for (int i = 0; i < 6; i++) begin
            cyc(i % 2 == 0, 0, 8'h00, 8'h00, i % 2 == 1, 0, 8'h01, 8'h00, 0);
            if (i > 0)
                chk("t5_route", {30'd0, core_rvalid, host_rvalid},
                    (i % 2 == 1) ? 32'd2 : 32'd1);
        end
        idle();

        // host withdraws before grant, aging restarts
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 8'(8'h30 + i), 8'h00, 1, 0, 8'h40, 8'h00, 0);
            chk("t6_denied", {31'd0, host_gnt}, 32'd0);
        end
        cyc(1, 0, 8'h32, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        chk("t6_core_only", {23'd0, ram_rden, ram_addr}, {23'd1, 8'h32});
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 8'(8'h50 + i), 8'h00, 1, 0, 8'h40, 8'h00, 0);
            chk("t6_aging", {31'd0, host_gnt}, {31'd0, i == 4});
        end
        idle();

        // reset with a pending locked host read
        cyc(0, 0, 8'h00, 8'h00, 1, 0, 8'h07, 8'h00, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t1_reset",
            {27'd0, core_rvalid, host_rvalid, ram_rden, ram_wren, host_locked},
            32'd0);
        host_req = 1'b0;
        host_lock = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // random traffic under the hold-until-grant rule
        cg_seen = 1'b0;
        hg_seen = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #1;
            if (core_req && !cg_seen) begin
                if ($urandom_range(15) == 0) core_req = 1'b0;
            end else begin
                core_req = $urandom_range(3) != 0;
                core_we = 1'($urandom);
                core_addr = 8'($urandom_range(15));
                core_wdata = 8'($urandom);
            end
            if (host_req && !hg_seen) begin
                if ($urandom_range(15) == 0) host_req = 1'b0;
            end else begin
                host_req = $urandom_range(2) == 0;
                host_we = 1'($urandom);
                host_addr = 8'($urandom_range(15));
                host_wdata = 8'($urandom);
                host_lock = $urandom_range(3) == 0;
            end
            @(negedge clk);
            cg_seen = core_gnt;
            hg_seen = host_gnt;
        end
        idle();
        idle();
        chk("drain", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
